// File: rtl/mult_seq_controller.sv
// -----------------------------------------------------------------------------
// mult_seq_controller
//
// Sequences an external 32x32 signed iterative multiplier. It accepts an
// operand pair, holds the multiplier in clear for one LOAD cycle, and lets it
// run for N_ITER cycles. It waits one further cycle for the accumulator to
// settle, then captures the 64-bit result and offers it downstream with a
// valid/ready handshake. A new pair may be accepted on the same edge that
// releases the previous product.
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous active-low reset
//   in_valid     in   1   operand pair present on in_a / in_b
//   in_ready     out  1   block accepts an operand pair
//   in_a         in   32  multiplicand (signed)
//   in_b         in   32  multiplier (signed)
//   mul_a        out  32  registered multiplicand to the multiplier
//   mul_b        out  32  registered multiplier to the multiplier
//   mul_reset    out  1   active-high synchronous clear to the multiplier
//   mul_result   in   64  multiplier accumulator
//   out_valid    out  1   out_product holds a completed product
//   out_ready    in   1   consumer accepts the product
//   out_product  out  64  registered signed product
//   busy         out  1   high in LOAD, RUN and WAIT
// -----------------------------------------------------------------------------
module mult_seq_controller #(
  parameter int CNT_W  = 6,
  parameter int N_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_reset,
  input  logic [63:0] mul_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product,
  output logic        busy
);

  if (CNT_W < 6 || (1 << CNT_W) < N_ITER) begin : g_bad_params
    $error("mult_seq_controller: CNT_W too narrow for N_ITER");
  end

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_product_q, out_product_d;
  logic             accept;

  // in_ready in DONE follows out_ready combinationally, so a release and a
  // new accept can share one edge without an IDLE bubble.
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_reset = !((state_q == S_RUN) || (state_q == S_WAIT));
  assign busy      = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_WAIT);

  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;

  always_comb begin
    // NOTE: every next-state signal gets a default here first; a path that
    // leaves one unassigned would infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
    mul_a_d       = accept ? in_a : mul_a_q;
    mul_b_d       = accept ? in_b : mul_b_q;

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Result is passed through untouched; the multiplier owns the sign.
        out_product_d = mul_result;
        out_valid_d   = 1'b1;
        state_d       = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = in_valid ? S_LOAD : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state registers, including the operand and product registers,
  // are cleared by the asynchronous reset so an abort discards any pending
  // product and the outputs reach known values without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
    end
  end

endmodule
